// File: rtl/fmps_test_pkg.sv
// Shared field layout, status codes and state encodings for the FMPS test packet
// writer and link checker.
package fmps_test_pkg;

    localparam logic [15:0] HEADER_MAGIC_DEFAULT = 16'hB6CF;
    localparam logic [15:0] DATA_MAGIC_DEFAULT   = 16'hCACA;

    localparam int unsigned MAGIC_WIDTH    = 16;
    localparam int unsigned FA_WIDTH       = 8;
    localparam int unsigned HDR_MAGIC_LSB  = 16;
    localparam int unsigned HDR_ENABLE_BIT = 15;
    localparam int unsigned HDR_INDEX_LSB  = 10;
    localparam int unsigned DATA_ZERO_LSB  = 29;
    localparam int unsigned DATA_COUNT_LSB = 24;
    localparam int unsigned DATA_MAGIC_LSB = 8;

    typedef enum logic [1:0] {
        StatusOk   = 2'd0,
        StatusHdr  = 2'd1,
        StatusData = 2'd2,
        StatusSeq  = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        StHdr  = 3'd0,
        StData = 3'd1,
        StDrop = 3'd2
    } chk_state_e;

endpackage

// File: rtl/fmps_test_link_checker_if.sv
// Receive-side AXI-Stream bundle for the FMPS test packets.
interface fmps_test_link_checker_if;

    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/fmps_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module fmps_sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] countQ;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            countQ <= '0;
        end else if (clear_i) begin
            countQ <= '0;
        end else if (inc_i && (countQ != '1)) begin
            countQ <= countQ + 1'b1;
        end
    end

    assign count_o = countQ;

endmodule

// File: rtl/fmps_test_link_checker.sv
// Far-end checker for the two-word FMPS test packets; one verdict per packet.
// Optional header-to-data watchdog: define FMPS_CHECK_TIMEOUT_EN.
module fmps_test_link_checker
    import fmps_test_pkg::*;
#(
    parameter logic [15:0] HEADER_MAGIC = HEADER_MAGIC_DEFAULT,
    parameter logic [15:0] DATA_MAGIC   = DATA_MAGIC_DEFAULT,
    parameter int unsigned MAX_FMPSS    = 32,
    parameter int unsigned COUNT_WIDTH  = 16,
`ifdef FMPS_CHECK_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 255,
`endif
    localparam int unsigned IdxW = $clog2(MAX_FMPSS)
) (
    input  logic                   auroraUserClk,
    input  logic                   auroraUserRstN,
    input  logic                   auroraFAstrobe,
    input  logic                   countClear,
    input  logic [IdxW-1:0]        expectedIndexBase,
    fmps_test_link_checker_if.slave FMPS_TEST_AXI_STREAM_RX,
    output logic                   TESTstatusStrobe,
    output logic [1:0]             TESTstatusCode,
    output logic [COUNT_WIDTH-1:0] goodPacketCount,
    output logic [COUNT_WIDTH-1:0] badPacketCount,
    output logic [7:0]             lastFAcycle,
    output logic [5:0]             sessionPacketCount,
    output logic [2:0]             dbgChkState
);

    chk_state_e          stateQ;
    status_e             pendingQ;
    status_e             codeQ;
    logic                readyQ;
    logic                strobeQ;
    logic [IdxW-1:0]     seqQ;
    logic [5:0]          sessCntQ;
    logic [FA_WIDTH-1:0] lastFAQ;
    logic [FA_WIDTH-1:0] sessionFAQ;
    logic [FA_WIDTH-1:0] prevFAQ;
    logic                sessionFAValidQ;
    logic                histValidQ;

    logic [31:0]         word;
    logic                last;
    logic                beat;
    logic [IdxW-1:0]     idxExpected;
    logic [FA_WIDTH-1:0] faField;
    logic [FA_WIDTH-1:0] faNext;
    logic                hdrGood;
    logic                dataFormOk;
    logic                faOk;
    status_e             dataCode;
    logic                verdictFire;
    status_e             verdictCode;
    logic                timeoutHit;

    assign word = FMPS_TEST_AXI_STREAM_RX.tdata;
    assign last = FMPS_TEST_AXI_STREAM_RX.tlast;
    // A beat coinciding with the session strobe is dropped on the floor.
    assign beat = FMPS_TEST_AXI_STREAM_RX.tvalid && readyQ && !auroraFAstrobe;
    assign FMPS_TEST_AXI_STREAM_RX.tready = readyQ;

`ifdef FMPS_CHECK_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    logic [TimerW-1:0] timerQ;

    assign timeoutHit = (stateQ == StData) && !beat && !auroraFAstrobe && (timerQ == TimerLast);

    always_ff @(posedge auroraUserClk or negedge auroraUserRstN) begin
        if (!auroraUserRstN) begin
            timerQ <= '0;
        end else if ((stateQ != StData) || beat || auroraFAstrobe) begin
            timerQ <= '0;
        end else begin
            timerQ <= timerQ + 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        idxExpected = expectedIndexBase + seqQ;
        faField     = word[FA_WIDTH-1:0];
        faNext      = prevFAQ + 1'b1;
        hdrGood     = (word[HDR_MAGIC_LSB +: MAGIC_WIDTH] == HEADER_MAGIC) &&
                      word[HDR_ENABLE_BIT] && (word[HDR_INDEX_LSB-1:0] == '0) && !last &&
                      (word[HDR_INDEX_LSB +: IdxW] == idxExpected);
        dataFormOk  = (word[DATA_MAGIC_LSB +: MAGIC_WIDTH] == DATA_MAGIC) &&
                      (word[31:DATA_ZERO_LSB] == '0);

        // FA must stay fixed within a session and advance by one across sessions.
        if (sessionFAValidQ) begin
            faOk = (faField == sessionFAQ);
        end else if (histValidQ) begin
            faOk = (faField == faNext);
        end else begin
            faOk = 1'b1;
        end

        if (!dataFormOk) begin
            dataCode = StatusData;
        end else if ((word[DATA_COUNT_LSB +: IdxW] != seqQ) || !faOk) begin
            dataCode = StatusSeq;
        end else begin
            dataCode = StatusOk;
        end

        verdictFire = 1'b0;
        verdictCode = StatusOk;
        if (beat && last) begin
            case (stateQ)
                StHdr: begin
                    if (!hdrGood) begin
                        verdictFire = 1'b1;
                        verdictCode = StatusHdr;
                    end
                end
                StData: begin
                    verdictFire = 1'b1;
                    verdictCode = dataCode;
                end
                StDrop: begin
                    verdictFire = 1'b1;
                    verdictCode = pendingQ;
                end
                default: ;
            endcase
        end
        if (timeoutHit) begin
            verdictFire = 1'b1;
            verdictCode = StatusData;
        end
    end

    always_ff @(posedge auroraUserClk or negedge auroraUserRstN) begin
        if (!auroraUserRstN) begin
            stateQ          <= StHdr;
            pendingQ        <= StatusOk;
            codeQ           <= StatusOk;
            readyQ          <= 1'b0;
            strobeQ         <= 1'b0;
            seqQ            <= '0;
            sessCntQ        <= '0;
            lastFAQ         <= '0;
            sessionFAQ      <= '0;
            prevFAQ         <= '0;
            sessionFAValidQ <= 1'b0;
            histValidQ      <= 1'b0;
        end else begin
            readyQ  <= 1'b1;
            strobeQ <= verdictFire;
            if (verdictFire) begin
                codeQ    <= verdictCode;
                seqQ     <= seqQ + 1'b1;
                sessCntQ <= sessCntQ + 1'b1;
                if (verdictCode == StatusOk) begin
                    lastFAQ <= faField;
                end
            end

            if (auroraFAstrobe) begin
                stateQ          <= StHdr;
                seqQ            <= '0;
                sessCntQ        <= '0;
                sessionFAValidQ <= 1'b0;
                if (sessionFAValidQ) begin
                    prevFAQ    <= sessionFAQ;
                    histValidQ <= 1'b1;
                end
            end else if (beat) begin
                case (stateQ)
                    StHdr: begin
                        if (hdrGood) begin
                            stateQ <= StData;
                        end else if (!last) begin
                            stateQ   <= StDrop;
                            pendingQ <= StatusHdr;
                        end
                    end
                    StData: begin
                        if (!last) begin
                            stateQ   <= StDrop;
                            pendingQ <= StatusData;
                        end else begin
                            stateQ <= StHdr;
                            if (dataFormOk && !sessionFAValidQ) begin
                                sessionFAQ      <= faField;
                                sessionFAValidQ <= 1'b1;
                            end
                        end
                    end
                    StDrop: begin
                        if (last) begin
                            stateQ <= StHdr;
                        end
                    end
                    default: stateQ <= StHdr;
                endcase
            end else if (timeoutHit) begin
                stateQ <= StHdr;
            end

            if (countClear) begin
                lastFAQ         <= '0;
                histValidQ      <= 1'b0;
                sessionFAValidQ <= 1'b0;
            end
        end
    end

    fmps_sat_counter #(
        .Width (COUNT_WIDTH)
    ) u_good_counter (
        .clk_i   (auroraUserClk),
        .rst_ni  (auroraUserRstN),
        .clear_i (countClear),
        .inc_i   (verdictFire && (verdictCode == StatusOk)),
        .count_o (goodPacketCount)
    );

    fmps_sat_counter #(
        .Width (COUNT_WIDTH)
    ) u_bad_counter (
        .clk_i   (auroraUserClk),
        .rst_ni  (auroraUserRstN),
        .clear_i (countClear),
        .inc_i   (verdictFire && (verdictCode != StatusOk)),
        .count_o (badPacketCount)
    );

    assign TESTstatusStrobe   = strobeQ;
    assign TESTstatusCode     = codeQ;
    assign lastFAcycle        = lastFAQ;
    assign sessionPacketCount = sessCntQ;
    assign dbgChkState        = stateQ;

endmodule

// File: tb/tb_fmps_test_link_checker.sv
// Bench for fmps_test_link_checker: fixed vectors, corner sequences, randomized packets.
module tb_fmps_test_link_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN;
    logic        faStrobe;
    logic        countClear;
    logic [4:0]  base;
    logic        strobe;
    logic [1:0]  code;
    logic [15:0] good;
    logic [15:0] bad;
    logic [7:0]  lastFA;
    logic [5:0]  sessCnt;
    logic [2:0]  st;
    logic        scClear;
    logic        scInc;
    logic [2:0]  scCount;

    fmps_test_link_checker_if rx ();

    fmps_test_link_checker dut (
        .auroraUserClk           (clk),
        .auroraUserRstN          (rstN),
        .auroraFAstrobe          (faStrobe),
        .countClear              (countClear),
        .expectedIndexBase       (base),
        .FMPS_TEST_AXI_STREAM_RX (rx),
        .TESTstatusStrobe        (strobe),
        .TESTstatusCode          (code),
        .goodPacketCount         (good),
        .badPacketCount          (bad),
        .lastFAcycle             (lastFA),
        .sessionPacketCount      (sessCnt),
        .dbgChkState             (st)
    );

    fmps_sat_counter #(
        .Width (3)
    ) satDut (
        .clk_i   (clk),
        .rst_ni  (rstN),
        .clear_i (scClear),
        .inc_i   (scInc),
        .count_o (scCount)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state (session/packet level).
    int mSeq, mSessFA, mPrevFA, mGood, mBad, mLastFA, mSessCnt;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          n;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStrobe();
        faStrobe = 1'b1;
        tick();
        faStrobe = 1'b0;
    endtask

    task automatic pulseClear();
        countClear = 1'b1;
        tick();
        countClear = 1'b0;
    endtask

    task automatic sendPkt(input logic [31:0] w [4], input int n,
                           output logic early, output logic fin, output logic [1:0] c);
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            rx.tdata  = w[i];
            rx.tvalid = 1'b1;
            rx.tlast  = (i == n - 1);
            tick();
            if (i < n - 1 && strobe) early = 1'b1;
        end
        fin = strobe;
        c = code;
        rx.tvalid = 1'b0;
        rx.tlast  = 1'b0;
    endtask

    task automatic pktCheck(input string name, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input int n, input logic [1:0] exp);
        logic [31:0] w [4];
        logic early, fin;
        logic [1:0] c;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = 32'h0;
        sendPkt(w, n, early, fin, c);
        check({name, "_early"}, {31'h0, early}, 32'h0);
        check({name, "_strobe"}, {31'h0, fin}, 32'h1);
        check({name, "_code"}, {30'h0, c}, {30'h0, exp});
    endtask

    function automatic logic [31:0] hdrWord(input logic [4:0] idx);
        return {16'hB6CF, 1'b1, idx, 10'h000};
    endfunction

    function automatic logic [31:0] dataWord(input logic [4:0] cnt, input logic [7:0] fa);
        return {3'b000, cnt, 16'hCACA, fa};
    endfunction

    function automatic int modelVerdict(input logic [31:0] w [4], input int n);
        logic [31:0] h, d;
        logic [7:0] fa;
        logic faOk;
        int idx;
        h = w[0];
        d = w[1];
        idx = (int'(base) + mSeq) % 32;
        if (h[31:16] != 16'hB6CF || !h[15] || h[9:0] != 10'h0 || n < 2 ||
            int'(h[14:10]) != idx) return 1;
        if (n > 2) return 2;
        if (d[23:8] != 16'hCACA || d[31:29] != 3'h0) return 2;
        fa = d[7:0];
        if (mSessFA >= 0) faOk = (int'(fa) == mSessFA);
        else faOk = (mPrevFA < 0) || (int'(fa) == (mPrevFA + 1) % 256);
        if (mSessFA < 0) mSessFA = int'(fa);
        if (int'(d[28:24]) != mSeq || !faOk) return 3;
        return 0;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] w [4];
        int n, r, fa, exp, hit;
        logic early, fin;
        logic [1:0] c;

        rstN = 1'b0; faStrobe = 1'b0; countClear = 1'b0; base = 5'd0;
        rx.tvalid = 1'b0; rx.tlast = 1'b0; rx.tdata = 32'h0;
        scClear = 1'b0; scInc = 1'b0;

        vecs[0] = '{32'hB6CF9000, 32'h00CACA07, 32'h0, 2, 2'd0};
        vecs[1] = '{32'hB6CF9400, 32'h01CACA07, 32'h0, 2, 2'd0};
        vecs[2] = '{32'hB6CF9800, 32'h02CACA07, 32'h0, 2, 2'd0};
        vecs[3] = '{32'hB6CE9000, 32'h03CACA07, 32'h0, 2, 2'd1};
        vecs[4] = '{32'hB6CFA000, 32'h0007CA0A, 32'h0, 2, 2'd2};
        vecs[5] = '{32'hB6CFA400, 32'h05CACA07, 32'h12345678, 3, 2'd2};

        // Reset values.
        repeat (3) tick();
        check("rst_tready", {31'h0, rx.tready}, 32'h0);
        check("rst_strobe", {31'h0, strobe}, 32'h0);
        check("rst_code", {30'h0, code}, 32'h0);
        check("rst_good", {16'h0, good}, 32'h0);
        check("rst_bad", {16'h0, bad}, 32'h0);
        check("rst_lastfa", {24'h0, lastFA}, 32'h0);
        check("rst_sesscnt", {26'h0, sessCnt}, 32'h0);
        check("rst_state", {29'h0, st}, 32'h0);
        rstN = 1'b1;
        tick();
        check("tready_after_rst", {31'h0, rx.tready}, 32'h1);

        // Saturating counter boundary.
        scClear = 1'b1; tick(); scClear = 1'b0;
        check("sat_clear", {29'h0, scCount}, 32'h0);
        scInc = 1'b1; repeat (10) tick();
        check("sat_hold", {29'h0, scCount}, 32'h7);
        scClear = 1'b1; tick(); scClear = 1'b0; scInc = 1'b0;
        check("sat_clear_wins", {29'h0, scCount}, 32'h0);

        // Fixed vectors.
        base = 5'd4;
        pulseStrobe();
        for (int i = 0; i < 6; i++) begin
            pktCheck($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].n,
                     vecs[i].code);
        end
        check("vec_good", {16'h0, good}, 32'd3);
        check("vec_bad", {16'h0, bad}, 32'd3);
        check("vec_lastfa", {24'h0, lastFA}, 32'h07);
        check("vec_sesscnt", {26'h0, sessCnt}, 32'd6);

        // FA continuity across sessions, and history cleared by countClear.
        pulseClear();
        base = 5'd0;
        pulseStrobe();
        pktCheck("fa_s1", 32'hB6CF8000, 32'h00CACA07, 32'h0, 2, 2'd0);
        pulseStrobe();
        pktCheck("fa_s2_skip", 32'hB6CF8000, 32'h00CACA09, 32'h0, 2, 2'd3);
        check("fa_good", {16'h0, good}, 32'd1);
        check("fa_bad", {16'h0, bad}, 32'd1);
        pulseClear();
        check("clr_good", {16'h0, good}, 32'd0);
        check("clr_bad", {16'h0, bad}, 32'd0);
        check("clr_lastfa", {24'h0, lastFA}, 32'h0);
        pulseStrobe();
        pktCheck("fa_after_clr", 32'hB6CF8000, 32'h00CACA20, 32'h0, 2, 2'd0);
        check("fa_after_clr_lastfa", {24'h0, lastFA}, 32'h20);

        // Session strobe abandons a half-received packet.
        rx.tdata = 32'hB6CF8400; rx.tvalid = 1'b1; rx.tlast = 1'b0;
        tick();
        check("abandon_hdr_strobe", {31'h0, strobe}, 32'h0);
        check("abandon_hdr_state", {29'h0, st}, 32'h1);
        rx.tdata = 32'h01CACA20; rx.tlast = 1'b1; faStrobe = 1'b1;
        tick();
        faStrobe = 1'b0; rx.tvalid = 1'b0; rx.tlast = 1'b0;
        check("abandon_strobe", {31'h0, strobe}, 32'h0);
        check("abandon_state", {29'h0, st}, 32'h0);
        check("abandon_sesscnt", {26'h0, sessCnt}, 32'h0);
        pktCheck("abandon_next", 32'hB6CF8000, 32'h00CACA21, 32'h0, 2, 2'd0);
        check("abandon_next_sesscnt", {26'h0, sessCnt}, 32'd1);

        // Header followed by a long silence.
        rx.tdata = 32'hB6CF8400; rx.tvalid = 1'b1; rx.tlast = 1'b0;
        tick();
        rx.tvalid = 1'b0;
        hit = 0;
        for (int i = 1; i <= 300 && hit == 0; i++) begin
            tick();
            if (strobe) hit = i;
        end
`ifdef FMPS_CHECK_TIMEOUT_EN
        check("timeout_cycle", hit, 32'd255);
        check("timeout_code", {30'h0, code}, 32'h2);
        check("timeout_state", {29'h0, st}, 32'h0);
        check("timeout_bad", {16'h0, bad}, 32'd1);
`else
        check("wait_no_verdict", hit, 32'd0);
        check("wait_state", {29'h0, st}, 32'h1);
`endif
        pulseStrobe();

        // countClear coinciding with a verdict.
        rx.tdata = 32'hB6CF8000; rx.tvalid = 1'b1; rx.tlast = 1'b0;
        tick();
        rx.tdata = 32'h00CACA22; rx.tlast = 1'b1; countClear = 1'b1;
        tick();
        countClear = 1'b0; rx.tvalid = 1'b0; rx.tlast = 1'b0;
        check("clrv_strobe", {31'h0, strobe}, 32'h1);
        check("clrv_code", {30'h0, code}, 32'h0);
        check("clrv_good", {16'h0, good}, 32'h0);
        check("clrv_bad", {16'h0, bad}, 32'h0);
        check("clrv_lastfa", {24'h0, lastFA}, 32'h0);

        // Randomized packets against the reference model.
        pulseClear();
        pulseStrobe();
        mSeq = 0; mSessFA = -1; mPrevFA = -1; mGood = 0; mBad = 0; mLastFA = 0; mSessCnt = 0;
        for (int p = 0; p < 80; p++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                pulseClear();
                mGood = 0; mBad = 0; mLastFA = 0; mPrevFA = -1; mSessFA = -1;
            end else if (r <= 3) begin
                base = 5'($urandom_range(0, 31));
                pulseStrobe();
                if (mSessFA >= 0) mPrevFA = mSessFA;
                mSessFA = -1; mSeq = 0; mSessCnt = 0;
            end
            if (mSessFA >= 0) fa = mSessFA;
            else if (mPrevFA >= 0) fa = (mPrevFA + 1) % 256;
            else fa = int'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) fa = int'($urandom_range(0, 255));
            w[0] = hdrWord(5'((int'(base) + mSeq) % 32));
            w[1] = dataWord(5'(mSeq), 8'(fa));
            w[2] = $urandom;
            w[3] = 32'h0;
            n = 2;
            case ($urandom_range(0, 11))
                0: w[0] ^= 32'h1 << $urandom_range(16, 31);
                1: begin w[0] ^= 32'h1 << $urandom_range(0, 9); n = 1; end
                2: w[1] ^= 32'h1 << $urandom_range(8, 23);
                3: w[1] ^= 32'h0100_0000 << $urandom_range(0, 4);
                4: w[1] ^= 32'h1 << $urandom_range(0, 7);
                5: n = 3;
                6: w[0] ^= 32'h400 << $urandom_range(0, 4);
                7: w[1] ^= 32'h2000_0000 << $urandom_range(0, 2);
                8: w[0] ^= 32'h8000;
                default: ;
            endcase
            exp = modelVerdict(w, n);
            mSeq = (mSeq + 1) % 32;
            mSessCnt++;
            if (exp == 0) begin
                mGood++;
                mLastFA = int'(w[1][7:0]);
            end else begin
                mBad++;
            end
            sendPkt(w, n, early, fin, c);
            check($sformatf("rnd%0d_early", p), {31'h0, early}, 32'h0);
            check($sformatf("rnd%0d_strobe", p), {31'h0, fin}, 32'h1);
            check($sformatf("rnd%0d_code", p), {30'h0, c}, exp);
            check($sformatf("rnd%0d_good", p), {16'h0, good}, mGood);
            check($sformatf("rnd%0d_bad", p), {16'h0, bad}, mBad);
            check($sformatf("rnd%0d_lastfa", p), {24'h0, lastFA}, mLastFA);
            check($sformatf("rnd%0d_sesscnt", p), {26'h0, sessCnt}, mSessCnt);
            check($sformatf("rnd%0d_state", p), {29'h0, st}, 32'h0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fmps_test_link_checker.md
Name: fmps_test_link_checker

Overview:
- Receive-side checker for the dummy FMPS test packets carried over the Aurora link.
- Sits directly downstream of the FMPS test packet writer, on the far end of the link. Consumes the two-word packets: a header word, then a data word carrying tlast.
- Validates framing, magics, FMPS index sequence, data counter and FA cycle counter. Reports one status per packet and keeps saturating good/bad counters for link bring-up.

Parameters:
- HEADER_MAGIC, 16'hB6CF, expected header[31:16].
- DATA_MAGIC, 16'hCACA, expected data[23:8].
- MAX_FMPSS, 32, packets per session before the index wraps; index width = $clog2(MAX_FMPSS) = 5.
- COUNT_WIDTH, 16, width of the good/bad packet counters.
- TIMEOUT_CYCLES, 255, header-to-data watchdog limit (used only with the optional feature).

Ports:
- auroraUserClk  in  1  Aurora user clock; the only clock.
- auroraUserRstN  in  1  asynchronous, active-low reset.
- auroraFAstrobe  in  1  start of a new session; one cycle wide.
- countClear  in  1  clears the counters and the FA history.
- expectedIndexBase  in  5  FMPS index expected for the first packet of a session.
- FMPS_TEST_AXI_STREAM_RX_tdata  in  32  received word.
- FMPS_TEST_AXI_STREAM_RX_tvalid  in  1  word valid.
- FMPS_TEST_AXI_STREAM_RX_tlast  in  1  last word of packet.
- FMPS_TEST_AXI_STREAM_RX_tready  out  1  word accepted.
- TESTstatusStrobe  out  1  one-cycle pulse per packet verdict.
- TESTstatusCode  out  2  0 OK, 1 header error, 2 data error, 3 sequence error.
- goodPacketCount  out  COUNT_WIDTH  saturating count of OK packets.
- badPacketCount  out  COUNT_WIDTH  saturating count of failed packets.
- lastFAcycle  out  8  FA cycle from the most recent OK data word.
- sessionPacketCount  out  6  packets with a verdict in the current session.
- dbgChkState  out  3  state register.

Behaviour:
- Reset values: all outputs 0. tready is 0 while reset is asserted and 1 from the first clock after release, then stays 1. Beat accepted = tvalid && tready.
- Header layout:
  - [31:16] magic
  - [15] enabled, must be 1
  - [14:10] FMPS index
  - [9:0] zero
- Data layout:
  - [31:29] zero
  - [28:24] data counter
  - [23:8] magic
  - [7:0] FA cycle
- seq is a 5-bit session packet counter. It is cleared by auroraFAstrobe and increments, wrapping, after every verdict.
- ST_HDR (0), header beat:
  - Header is good if magic matches, enabled=1, [9:0]=0, tlast=0, and index == expectedIndexBase+seq (mod 32). Good header -> ST_DATA.
  - Bad header with tlast=1 -> code 1 verdict, stay in ST_HDR.
  - Bad header with tlast=0 -> ST_DROP with pending code 1.
- ST_DATA (1), data beat:
  - tlast=0 -> ST_DROP with pending code 2.
  - Otherwise, magic mismatch or [31:29]!=0 -> code 2.
  - Otherwise, data counter != seq, or FA-cycle violation -> code 3.
  - Otherwise code 0.
  - With tlast=1, return to ST_HDR.
- FA rule:
  - The first data word of a session latches sessionFA.
  - Later words in the session must equal sessionFA.
  - sessionFA must equal the previous session's FA+1 (mod 256), unless history is empty (after reset or countClear).
- ST_DROP (2): discard beats until a tlast beat, then issue the pending verdict and go to ST_HDR.
- Verdict: registered, one cycle after the completing beat. TESTstatusStrobe=1 for one cycle; the code and counters update in the same cycle. Counters saturate at all-ones.
- auroraFAstrobe:
  - Has priority over everything, in any state. Next state is ST_HDR and seq=0.
  - A beat accepted in the same cycle is discarded. A partial packet is abandoned with no verdict.
  - sessionPacketCount is cleared.
- countClear: clears the good/bad counters, lastFAcycle and FA history. It does not change state. If it coincides with a verdict, clear wins.

Optional Feature:
- Macro: FMPS_CHECK_TIMEOUT_EN.
- Defined: a cycle counter runs while in ST_DATA and resets on every accepted beat. On reaching TIMEOUT_CYCLES it issues a code 2 verdict, increments badPacketCount and returns to ST_HDR.
- Undefined: ST_DATA waits indefinitely; no counter logic is present.

Decomposition:
- Package fmps_test_pkg:
  - header and data field offsets and widths
  - the status code constants (OK/HDR/DATA/SEQ)
  - state encodings
  - the default magics
- The writer's next revision also uses this package.
- One sub-module: fmps_sat_counter, a parameterised saturating counter with clear and increment, instantiated twice.

Test Plan:
- Strobe, then 3 good packets with expectedIndexBase=4:
  - headers 32'hB6CF9000, 32'hB6CF9400, 32'hB6CF9800
  - data {seq,CACA,FA=07}
  - -> 3 strobes, code 0, goodPacketCount=3, lastFAcycle=8'h07.
- Header 32'hB6CE9000 (bad magic) with tlast=0, then data with tlast=1 -> one code 1 verdict; badPacketCount=1.
- Data word 32'h0007CA0A (magic 0x07CA) -> code 2. Data word with tlast=0 followed by an extra tlast beat -> a single code 2 after the extra beat.
- Session with FA=07, then next session FA=09 -> second session's first packet gets code 3. Then countClear; a session with FA=20 -> code 0.
- auroraFAstrobe in the cycle after a good header -> no verdict. The next header with index=base and counter 0 -> code 0.
- With FMPS_CHECK_TIMEOUT_EN: good header, then tvalid held low for 255 cycles -> code 2 strobe, state returns to ST_HDR.
